sgbm_clk_rst_seq: RTL and testbench

SGBM_CLK_RST_SEQ -- requirements
Module: sgbm_clk_rst_seq

---
 rtl/sgbm_clk_rst_seq.sv | 180 ++++++++++++++++++
 tb/tb_sgbm_clk_rst_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgbm_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// sgbm_clk_rst_seq
//
// Purpose:
//   Brings up the SGBM clock domain. It holds the PLL in reset, waits for lock,
//   requires lock to stay high for a while, and then releases the SGBM pipeline
//   reset. If lock never arrives, the PLL is re-reset a bounded number of times
//   before the block parks in FAIL. A lock loss while running is counted, and
//   the whole sequence is then re-run.
//
// Ports:
//   clk          in   system clock; all logic runs on its rising edge
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock status (asynchronous to clk)
//   restart_req  in   one-cycle request to re-run bring-up (RUN / FAIL only)
//   pll_rst      out  active-high PLL reset
//   sgbm_rst     out  active-high SGBM pipeline reset
//   ready        out  clock stable and pipeline released
//   fail         out  retries exhausted without lock
//   state        out  current FSM state code
//   lost_count   out  saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
module sgbm_clk_rst_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STABLE_CYCLES  = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       sgbm_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] lost_count
);

    // One shared counter wide enough for the longest dwell.
    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retries_q, retries_d;
    logic [7:0]       lost_q, lost_d;
    logic [1:0]       sync_q;
    logic             lock_s;

    // Two-flop synchronizer; only lock_s is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lock_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retries_q <= 8'd0;
            lost_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            lost_q    <= lost_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        lost_d    = lost_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == LOCK_LAST) begin
                    // Retries only ever count up to the limit, so equality is
                    // the exhaustion test and the register cannot overshoot.
                    if (retries_q == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        retries_d = retries_q + 8'd1;
                        state_d   = ST_PLL_RST;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STABLE: begin
                // A drop during qualification is not a failed attempt; wait
                // again without consuming a retry.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                // Lock loss wins over a coincident restart request.
                if (!lock_s) begin
                    state_d = ST_LOST;
                end else if (restart_req) begin
                    retries_d = 8'd0;
                    state_d   = ST_PLL_RST;
                end
            end

            ST_LOST: begin
                if (lost_q != 8'hFF) begin
                    lost_d = lost_q + 8'd1;
                end
                retries_d = 8'd0;
                state_d   = ST_PLL_RST;
            end

            ST_FAIL: begin
                if (restart_req) begin
                    retries_d = 8'd0;
                    state_d   = ST_PLL_RST;
                end
            end

            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        // Every state starts its dwell from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Moore outputs straight from the state register.
    assign pll_rst    = (state_q == ST_PLL_RST);
    assign ready      = (state_q == ST_RUN);
    assign sgbm_rst   = (state_q != ST_RUN);
    assign fail       = (state_q == ST_FAIL);
    assign state      = state_q;
    assign lost_count = lost_q;

endmodule

// File: tb/tb_sgbm_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_sgbm_clk_rst_seq
//
// Directed bench for sgbm_clk_rst_seq with small parameters. A behavioural
// model tracks remaining dwell time per phase and is compared with the DUT on
// every falling edge; directed steps also pin literal expectations at known
// edge numbers.
// -----------------------------------------------------------------------------
module tb_sgbm_clk_rst_seq;

    localparam int P_RST = 4;
    localparam int P_TO  = 8;
    localparam int P_ST  = 5;
    localparam int P_MR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst;
    logic       sgbm_rst;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [7:0] lost_count;

    int errors = 0;
    int checks = 0;

    sgbm_clk_rst_seq #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .STABLE_CYCLES (P_ST),
        .MAX_RETRIES   (P_MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart_req(restart_req),
        .pll_rst    (pll_rst),
        .sgbm_rst   (sgbm_rst),
        .ready      (ready),
        .fail       (fail),
        .state      (state),
        .lost_count (lost_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: phase plus "edges left" in that phase.
    // Phases: 0 PLL reset, 1 waiting for lock, 2 qualifying, 3 running,
    // 4 lost, 5 failed.
    // ------------------------------------------------------------------
    int m_phase = 0;
    int m_left  = P_RST;
    int m_retry = 0;
    int m_lost  = 0;
    bit m_lk1   = 1'b0;
    bit m_lk2   = 1'b0;
    bit chk_en  = 1'b0;

    function automatic int dwell(input int ph);
        case (ph)
            0:       return P_RST;
            1:       return P_TO;
            2:       return P_ST;
            default: return 0;
        endcase
    endfunction

    task automatic go(input int ph);
        m_phase = ph;
        m_left  = dwell(ph);
    endtask

    task automatic model_step();
        bit lk;
        lk = m_lk2;
        if (rst) begin
            go(0);
            m_retry = 0;
            m_lost  = 0;
            m_lk1   = 1'b0;
            m_lk2   = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_left = m_left - 1;
                    if (m_left == 0) go(1);
                end
                1: begin
                    if (lk) begin
                        go(2);
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            if (m_retry >= P_MR) begin
                                go(5);
                            end else begin
                                m_retry = m_retry + 1;
                                go(0);
                            end
                        end
                    end
                end
                2: begin
                    if (!lk) begin
                        go(1);
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) go(3);
                    end
                end
                3: begin
                    if (!lk) begin
                        go(4);
                    end else if (restart_req) begin
                        m_retry = 0;
                        go(0);
                    end
                end
                4: begin
                    m_lost  = (m_lost < 255) ? m_lost + 1 : 255;
                    m_retry = 0;
                    go(0);
                end
                default: begin
                    if (restart_req) begin
                        m_retry = 0;
                        go(0);
                    end
                end
            endcase
            m_lk2 = m_lk1;
            m_lk1 = pll_locked;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mdl_state",    int'(state),      m_phase);
                check("mdl_pll_rst",  int'(pll_rst),    (m_phase == 0) ? 1 : 0);
                check("mdl_sgbm_rst", int'(sgbm_rst),   (m_phase != 3) ? 1 : 0);
                check("mdl_ready",    int'(ready),      (m_phase == 3) ? 1 : 0);
                check("mdl_fail",     int'(fail),       (m_phase == 5) ? 1 : 0);
                check("mdl_lost",     int'(lost_count), m_lost);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},    int'(state),      0);
        check({tag, "_pll_rst"},  int'(pll_rst),    1);
        check({tag, "_sgbm_rst"}, int'(sgbm_rst),   1);
        check({tag, "_ready"},    int'(ready),      0);
        check({tag, "_fail"},     int'(fail),       0);
        check({tag, "_lost"},     int'(lost_count), 0);
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_ready", int'(ready === 1'b1), 1);
    endtask

    initial begin
        // ---------------- Bring-up with lock held high ----------------
        pll_locked = 1'b1;
        do_reset();
        chk_en = 1'b1;
        check_reset_values("rst0");

        tick(1);                       // edge 1
        restart_req = 1'b1;            // ignored in PLL_RST
        tick(1);                       // edge 2
        restart_req = 1'b0;
        tick(1);                       // edge 3
        check("up_e3_pll_rst", int'(pll_rst), 1);
        tick(1);                       // edge 4
        check("up_e4_state", int'(state), 1);
        check("up_e4_pll_rst", int'(pll_rst), 0);
        tick(1);                       // edge 5
        check("up_e5_state", int'(state), 2);
        tick(4);                       // edge 9
        check("up_e9_ready", int'(ready), 0);
        tick(1);                       // edge 10
        check("up_e10_ready", int'(ready), 1);
        check("up_e10_sgbm_rst", int'(sgbm_rst), 0);

        // ---------------- Lock loss in RUN (k = 14) ----------------
        tick(3);                       // edge 13
        pll_locked = 1'b0;
        tick(2);                       // edge 15
        check("loss_k1_state", int'(state), 3);
        tick(1);                       // edge 16
        check("loss_k2_state", int'(state), 4);
        check("loss_k2_sgbm_rst", int'(sgbm_rst), 1);
        check("loss_k2_ready", int'(ready), 0);
        tick(1);                       // edge 17
        check("loss_k3_state", int'(state), 0);
        check("loss_k3_lost", int'(lost_count), 1);

        // ---------------- Glitch during STABLE ----------------
        pll_locked = 1'b1;
        tick(5);                       // edge 22
        check("gl_e22_state", int'(state), 2);
        tick(1);                       // edge 23
        pll_locked = 1'b0;
        tick(1);                       // edge 24
        pll_locked = 1'b1;
        tick(2);                       // edge 26: lock_s low seen
        check("gl_e26_state", int'(state), 1);
        tick(1);                       // edge 27
        check("gl_e27_state", int'(state), 2);
        tick(4);                       // edge 31
        check("gl_e31_ready", int'(ready), 0);
        tick(1);                       // edge 32 = lock_s high + 6
        check("gl_e32_ready", int'(ready), 1);

        // ---------------- Restart in RUN ----------------
        restart_req = 1'b1;
        tick(1);                       // edge 33
        restart_req = 1'b0;
        check("rs_run_state", int'(state), 0);
        check("rs_run_lost", int'(lost_count), 1);
        tick(10);                      // edge 43
        check("rs_run_ready", int'(ready), 1);

        // ---------------- Lock loss beats restart ----------------
        pll_locked = 1'b0;
        tick(2);                       // edge 45, lock_s now low
        check("prio_pre_state", int'(state), 3);
        restart_req = 1'b1;
        tick(1);                       // edge 46
        restart_req = 1'b0;
        check("prio_state", int'(state), 4);
        tick(1);                       // edge 47
        check("prio_after_state", int'(state), 0);
        check("prio_after_lost", int'(lost_count), 2);

        // ---------------- Fail, then restart keeps lost_count ----------------
        tick(35);
        check("f1_pre_fail", int'(fail), 0);
        tick(1);
        check("f1_fail", int'(fail), 1);
        tick(3);
        check("f1_hold_state", int'(state), 5);
        restart_req = 1'b1;
        tick(1);
        restart_req = 1'b0;
        check("f1_rs_state", int'(state), 0);
        check("f1_rs_fail", int'(fail), 0);
        check("f1_rs_lost", int'(lost_count), 2);
        // Cleared retries mean a full three-attempt sequence again.
        tick(35);
        check("f2_pre_state", int'(state), 1);
        tick(1);
        check("f2_state", int'(state), 5);

        // ---------------- No lock from fresh reset ----------------
        do_reset();
        check_reset_values("rst1");
        tick(11);                      // edge 11
        check("nl_e11_state", int'(state), 1);
        tick(1);                       // edge 12: first timeout
        check("nl_e12_state", int'(state), 0);
        tick(23);                      // edge 35
        check("nl_e35_state", int'(state), 1);
        tick(1);                       // edge 36
        check("nl_e36_state", int'(state), 5);
        check("nl_e36_fail", int'(fail), 1);
        check("nl_e36_pll_rst", int'(pll_rst), 0);

        // ---------------- Reset mid-RUN ----------------
        pll_locked = 1'b1;
        restart_req = 1'b1;
        tick(1);
        restart_req = 1'b0;
        wait_ready(20);
        pll_locked = 1'b0;
        tick(4);
        check("mr_lost", int'(lost_count), 1);
        pll_locked = 1'b1;
        wait_ready(30);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_values("rst2");
        tick(3);
        check("mr_e3_state", int'(state), 0);
        tick(1);
        check("mr_e4_state", int'(state), 1);
        tick(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
